// File: rtl/lab5_mem_sequencer_if.sv
// Request, write-beat, read-return and memory-port signals between a requester and the Lab5 sequencer.
// Latency: none. This file only groups the wires.
// Backpressure: req_ready and wr_data_ready gate acceptance. Read data has no backpressure.
interface lab5_mem_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_len;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_valid;
    logic              wr_data_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              done;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    // The master side is the requester together with the word memory, so it also returns mem_dout.
    modport master (
        output req_valid, req_write, req_addr, req_len, wr_data, wr_data_valid, mem_dout,
        input  req_ready, wr_data_ready, rd_data, rd_valid, done, mem_addr, mem_write, mem_din
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_len, wr_data, wr_data_valid, mem_dout,
        output req_ready, wr_data_ready, rd_data, rd_valid, done, mem_addr, mem_write, mem_din
    );
endinterface

// File: rtl/lab5_mem_sequencer.sv
// Single/burst read-write sequencer driving the Lab5 word memory one beat per cycle.
// Latency: a write beat reaches mem_write 1 cycle after acceptance. Read beat k has rd_valid READ_LAT+2+k cycles after acceptance.
// Backpressure: one request at a time (req_ready only in IDLE), write beats stall on wr_data_valid, reads never stall.
module lab5_mem_sequencer #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lab5_mem_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR     = 2'd1,
        RD     = 2'd2,
        RDWAIT = 2'd3
    } state_t;

    // Selects every token stage except the capture stage (READ_LAT-1).
    localparam logic [READ_LAT-1:0] LOW_MASK = READ_LAT'((1 << (READ_LAT - 1)) - 1);

    state_t              state;
    logic [ADDR_W-1:0]   addr_cnt;
    logic [3:0]          beat_cnt;
    logic                iss;          // an address is on mem_addr this cycle for a read
    logic [READ_LAT-1:0] tok;          // tok[i]: read address issued i+1 cycles ago
    logic [READ_LAT-1:0] tok_nxt;
    logic                last_cap;

    logic                wr_rdy_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                rd_vld_q;
    logic                done_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_write_q;
    logic [DATA_W-1:0]   mem_din_q;

    // req_ready follows the state directly so that it is low while reset is held and high immediately after release.
    assign bus.req_ready     = rst_n & (state == IDLE);
    assign bus.wr_data_ready = wr_rdy_q;
    assign bus.rd_data       = rd_data_q;
    assign bus.rd_valid      = rd_vld_q;
    assign bus.done          = done_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_write     = mem_write_q;
    assign bus.mem_din       = mem_din_q;

    // Advance the read-token pipeline and detect the capture of the last outstanding read.
    always_comb begin
        tok_nxt  = (tok << 1) | READ_LAT'(iss);
        last_cap = (state == RDWAIT) && tok[READ_LAT-1] && !iss && ((tok & LOW_MASK) == '0);
    end

    // Request FSM with registered memory-port, read-return and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            beat_cnt    <= '0;
            iss         <= 1'b0;
            tok         <= '0;
            wr_rdy_q    <= 1'b0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
            done_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_din_q   <= '0;
        end else begin
            mem_write_q <= 1'b0;
            done_q      <= 1'b0;
            tok         <= tok_nxt;
            rd_vld_q    <= tok[READ_LAT-1];
            if (tok[READ_LAT-1]) begin
                rd_data_q <= bus.mem_dout;
            end

            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        beat_cnt <= bus.req_len;
                        if (bus.req_write) begin
                            state    <= WR;
                            addr_cnt <= bus.req_addr;
                            wr_rdy_q <= 1'b1;
                        end else begin
                            // The first read address goes out in the cycle right after acceptance.
                            state      <= RD;
                            mem_addr_q <= bus.req_addr;
                            addr_cnt   <= bus.req_addr + ADDR_W'(1);
                            iss        <= 1'b1;
                        end
                    end
                end

                WR: begin
                    if (bus.wr_data_valid) begin
                        mem_write_q <= 1'b1;
                        mem_addr_q  <= addr_cnt;
                        mem_din_q   <= bus.wr_data;
                        addr_cnt    <= addr_cnt + ADDR_W'(1);
                        if (beat_cnt == 4'd0) begin
                            // done lines up with the mem_write cycle of the final beat.
                            state    <= IDLE;
                            wr_rdy_q <= 1'b0;
                            done_q   <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt - 4'd1;
                        end
                    end
                end

                RD: begin
                    if (beat_cnt == 4'd0) begin
                        iss   <= 1'b0;
                        state <= RDWAIT;
                    end else begin
                        mem_addr_q <= addr_cnt;
                        addr_cnt   <= addr_cnt + ADDR_W'(1);
                        beat_cnt   <= beat_cnt - 4'd1;
                        iss        <= 1'b1;
                    end
                end

                RDWAIT: begin
                    // Leave on the capture edge of the last read, so done coincides with its rd_valid.
                    if (last_cap) begin
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lab5_mem_sequencer.md
# lab5_mem_sequencer

Request sequencer placed directly upstream of the Lab5 word memory (8-bit address, 32-bit data, single write strobe). Accepts single or burst read/write requests over a valid/ready handshake. Drives the memory's address, write and data inputs one beat per cycle and returns read data with a valid flag. Signals completion of each request with a one-cycle pulse.

## Interface
- ADDR_W, 8, memory address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 32, data word width
- READ_LAT, 1, cycles from mem_addr presented to mem_dout valid (legal 1..4)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted when req_valid & req_ready at a rising edge
- req_write  in  1  1 = write burst, 0 = read burst
- req_addr  in  ADDR_W  start address
- req_len  in  4  burst length minus one (0 → 1 beat, 15 → 16 beats)
- wr_data  in  DATA_W  write beat data
- wr_data_valid  in  1  write beat present
- wr_data_ready  out  1  high in WR state only
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  rd_data valid this cycle (no backpressure)
- done  out  1  one-cycle completion pulse
- mem_addr  out  ADDR_W  registered, to memory Address
- mem_write  out  1  registered, to memory Write
- mem_din  out  DATA_W  registered, to memory In
- mem_dout  in  DATA_W  from memory Dout

## Operation
- States: IDLE, WR, RD, RDWAIT.
- IDLE: on accept, latch req_addr into addr counter and req_len into beat counter; go WR if req_write else RD.
- WR: each edge with wr_data_valid high accepts one beat. Next cycle: mem_write=1, mem_addr=addr counter, mem_din=beat. Counter +1 mod 2^ADDR_W. Cycles without wr_data_valid: mem_write=0, mem_addr/mem_din hold. Final beat accepted → IDLE, done pulses in the cycle mem_write is high for that beat.
- RD: issue one address per cycle, no stalls; mem_write=0. Push a valid token into a READ_LAT-deep shift register per address. Final address issued → RDWAIT.
- RDWAIT: wait until token pipeline empty, then → IDLE. done pulses in the same cycle as the final rd_valid.
- Read capture: mem_dout sampled READ_LAT cycles after its address cycle, registered into rd_data, rd_valid high the following cycle.
- Wrap: address 255 + 1 → 0 inside a burst (ADDR_W=8); no error.
- Requests are not queued; req_ready=0 outside IDLE.
- Reset mid-burst aborts immediately: remaining beats dropped, in-flight read tokens cleared, no done, no rd_valid.

## Timing
- Reset values: req_ready=1 after reset release (IDLE), wr_data_ready=0, rd_valid=0, rd_data=0, done=0, mem_addr=0, mem_write=0, mem_din=0.
- Write: beat accepted at edge N → mem_write high during cycle N+1 → memory writes at edge N+1 end. Full-rate burst of L beats: L mem_write cycles back-to-back.
- Read: accept at edge N; first address in cycle N+1; rd_valid for beat k at cycle N+1+k+READ_LAT+1. L-beat burst: last rd_valid/done at cycle N+L+READ_LAT+1.
- done and req_ready may both be high in the same cycle; a new request can be accepted on the done edge (back-to-back).
- mem_write never high outside WR-issued beats; never high while reading.

## Test plan
- Reset: drive rst_n=0 mid-clock → all outputs 0 asynchronously; release → req_ready=1, mem_write=0.
- Single write/read: write addr 1 data 12, then read addr 1 len 0 → one mem_write cycle at addr 1 din 12; rd_data=12 with rd_valid exactly READ_LAT+2 cycles after read accept; done once per request.
- Burst with wrap: write len 3 from addr 254 data 20,21,22,23 → mem_addr 254,255,0,1; read back len 3 → rd_data 20,21,22,23 on consecutive cycles.
- Write stalls: toggle wr_data_valid 1,0,0,1 for len 1 → mem_write pulses only on accepted beats, addresses 2 then 3, done on second.
- Back-to-back: issue read immediately when done pulses → accepted that edge, no idle cycle, no dropped/duplicated rd_valid.
- Reset mid-read burst (len 15 at beat 5) → no further rd_valid, no done, req_ready=1 after release.
